// File: rtl/spi_ram_sequencer.sv
// SPI master that turns single-byte read/write requests into the two-frame
// address/data command sequence of the SPI slave + RAM wrapper.
module spi_ram_sequencer #(
    parameter int GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SEL, S_SHIFT, S_WAIT, S_RECV, S_GAP
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      bitcnt, bitcnt_nxt;
    logic [GW-1:0]   gapcnt, gapcnt_nxt;
    logic            phase, phase_nxt;
    logic            wr_q;
    logic [7:0]      addr_q, wdata_q, rx_q, rx_nxt;
    logic [1:0]      code;
    logic [9:0]      word;
    logic            accept, frame_end;
    logic            ss_nxt, mosi_nxt, ready_nxt, resp_nxt;
    logic [7:0]      rdata_nxt;

    assign accept = req_valid && req_ready;
    // Command code: bit 1 selects read, bit 0 selects the data (second) frame.
    assign code   = {~wr_q, phase};
    assign word   = {code, phase ? (wr_q ? wdata_q : 8'h00) : addr_q};

    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        gapcnt_nxt = gapcnt;
        phase_nxt  = phase;
        rx_nxt     = rx_q;
        frame_end  = 1'b0;
        resp_nxt   = 1'b0;
        rdata_nxt  = resp_rdata;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_START;
                    phase_nxt = 1'b0;
                end
            end
            S_START: state_nxt = S_SEL;
            S_SEL: begin
                state_nxt  = S_SHIFT;
                bitcnt_nxt = 4'd9;
            end
            S_SHIFT: begin
                if (bitcnt == 4'd0) begin
                    if (code == 2'b11) state_nxt = S_WAIT;
                    else               frame_end = 1'b1;
                end else begin
                    bitcnt_nxt = bitcnt - 4'd1;
                end
            end
            S_WAIT: begin
                state_nxt  = S_RECV;
                bitcnt_nxt = 4'd7;
            end
            S_RECV: begin
                rx_nxt = {rx_q[6:0], MISO};
                if (bitcnt == 4'd0) frame_end  = 1'b1;
                else                bitcnt_nxt = bitcnt - 4'd1;
            end
            S_GAP: begin
                if (gapcnt == '0) begin
                    if (phase) begin
                        state_nxt = S_IDLE;
                        resp_nxt  = 1'b1;
                        if (!wr_q) rdata_nxt = rx_nxt;
                    end else begin
                        state_nxt = S_START;
                        phase_nxt = 1'b1;
                    end
                end else begin
                    gapcnt_nxt = gapcnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // The final gap cycle after the data frame is spent in IDLE, so the
        // response and the next accept line up with the last SS_n-high cycle.
        if (frame_end) begin
            if (!phase) begin
                state_nxt  = S_GAP;
                gapcnt_nxt = GW'(GAP - 1);
            end else if (GAP == 1) begin
                state_nxt = S_IDLE;
                resp_nxt  = 1'b1;
                if (!wr_q) rdata_nxt = rx_nxt;
            end else begin
                state_nxt  = S_GAP;
                gapcnt_nxt = GW'(GAP - 2);
            end
        end

        ss_nxt    = (state_nxt == S_IDLE) || (state_nxt == S_GAP);
        ready_nxt = (state_nxt == S_IDLE);
        case (state_nxt)
            S_SEL:   mosi_nxt = code[1];
            S_SHIFT: mosi_nxt = word[bitcnt_nxt];
            default: mosi_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bitcnt     <= 4'd0;
            gapcnt     <= '0;
            phase      <= 1'b0;
            SS_n       <= 1'b1;
            MOSI       <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 8'h00;
        end else begin
            state      <= state_nxt;
            bitcnt     <= bitcnt_nxt;
            gapcnt     <= gapcnt_nxt;
            phase      <= phase_nxt;
            SS_n       <= ss_nxt;
            MOSI       <= mosi_nxt;
            req_ready  <= ready_nxt;
            resp_valid <= resp_nxt;
            resp_rdata <= rdata_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        rx_q <= rx_nxt;
    end

endmodule

// File: tb/tb_spi_ram_sequencer.sv
// Bench for spi_ram_sequencer: behavioural wrapper/RAM model on the SPI pins,
// frame and response scoreboards, plus a GAP=3 instance.
module tb_spi_ram_sequencer;

    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
    logic       req_ready, resp_valid, SS_n, MOSI;
    logic [7:0] resp_rdata;
    logic       MISO = 1'b0;

    logic       rv3 = 1'b0, rw3 = 1'b1;
    logic [7:0] ra3 = 8'h00, rd3 = 8'h00;
    logic       rr3, resp3, ss3, mosi3;
    logic [7:0] rdata3;
    logic       miso3 = 1'b0;

    spi_ram_sequencer #(.GAP(GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    spi_ram_sequencer #(.GAP(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3),
        .req_write(rw3), .req_addr(ra3), .req_wdata(rd3),
        .resp_valid(resp3), .resp_rdata(rdata3),
        .SS_n(ss3), .MOSI(mosi3), .MISO(miso3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [1:0] code; logic [7:0] pay; bit gapchk; } frame_t;
    typedef struct { logic [7:0] rdata; int acc; int lat; } resp_t;
    frame_t fq[$];
    resp_t  rq[$];

    logic [7:0] ref_mem   [256];
    logic [7:0] slave_mem [256];
    logic [7:0] model_last = 8'h00;

    // Wrapper model: decodes each observed frame and answers frame 11 on MISO.
    bit         in_frame = 0, abort_pending = 0;
    int         c = 0, hi_run = 0, prev_hi = 0;
    logic       bits [0:31];
    logic [7:0] s_addr = 8'h00, s_raddr = 8'h00;

    task automatic end_frame();
        logic [9:0] w;
        frame_t     f;
        for (int i = 0; i < 10; i++) w[9-i] = bits[2+i];
        if (abort_pending) begin
            abort_pending = 0;
            if (fq.size() != 0) void'(fq.pop_front());
            return;
        end
        if (fq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_frame: got word 0x%0h length %0d, none expected", w, c);
        end else begin
            f = fq.pop_front();
            chk("frame_len", c, (f.code == 2'b11) ? 21 : 12);
            chk("frame_bits", {bits[0], bits[1], w}, {1'b0, f.code[1], f.code, f.pay});
            if (f.code == 2'b11) chk("wait_mosi", bits[12], 1'b0);
            if (f.gapchk) chk("gap_len", prev_hi, GAP);
        end
        case (w[9:8])
            2'b00: s_addr = w[7:0];
            2'b01: slave_mem[s_addr] = w[7:0];
            2'b10: s_raddr = w[7:0];
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (SS_n === 1'b0) begin
            if (!in_frame) begin
                in_frame = 1;
                c = 0;
                prev_hi = hi_run;
            end
            if (c < 32) bits[c] = MOSI;
            if (c >= 13 && c <= 20 && bits[2] === 1'b1 && bits[3] === 1'b1)
                MISO <= slave_mem[s_raddr][20-c];
            else
                MISO <= 1'($urandom);
            c++;
            hi_run = 0;
        end else begin
            if (in_frame) end_frame();
            in_frame = 0;
            hi_run++;
            MISO <= 1'($urandom);
        end
    end

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_resp: got resp_valid with rdata 0x%0h, none expected", resp_rdata);
            end else begin
                resp_t r;
                r = rq.pop_front();
                chk("resp_rdata", resp_rdata, r.rdata);
                chk("latency", cyc - r.acc, r.lat);
                chk("ready_with_resp", req_ready, 1'b1);
            end
        end
    end

    task automatic issue(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input bit b2b, output int acc);
        int n;
        acc = -1;
        if (!b2b) begin
            n = 0;
            while ((rq.size() != 0 || req_ready !== 1'b1) && n < 300) begin
                @(negedge clk); n++;
            end
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        n = 0;
        while (req_ready !== 1'b1 && n < 300) begin
            @(negedge clk); n++;
        end
        if (req_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got req_ready=%b expected 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        acc = cyc;
        fq.push_back('{code: wr ? 2'b00 : 2'b10, pay: a, gapchk: b2b});
        fq.push_back('{code: wr ? 2'b01 : 2'b11, pay: wr ? d : 8'h00, gapchk: 1'b1});
        if (wr) begin
            rq.push_back('{rdata: model_last, acc: acc, lat: 24 + 2*GAP});
            ref_mem[a] = d;
        end else begin
            model_last = ref_mem[a];
            rq.push_back('{rdata: model_last, acc: acc, lat: 33 + 2*GAP});
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || req_ready !== 1'b1) && n < 500) begin
            @(negedge clk); n++;
        end
        chk("drain_pending", rq.size(), 0);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_ss_n"}, SS_n, 1'b1);
        chk({tag, "_mosi"}, MOSI, 1'b0);
        chk({tag, "_ready"}, req_ready, 1'b1);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_rdata"}, resp_rdata, 8'h00);
    endtask

    logic ss3_log [0:63];
    logic m3_log  [0:63];
    int   resp_k[$];
    int   runs [0:15];
    int   rs   [0:15];

    initial begin
        int         acc, nr, len, nacc;
        logic       cur;
        logic [9:0] w;
        logic [9:0] w3e [4];
        bit         chg;
        logic [7:0] addrs [8];

        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 8'($urandom);
            slave_mem[i] = ref_mem[i];
        end
        for (int i = 0; i < 8; i++) addrs[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        reset_check("reset");
        rst = 1'b0;
        @(negedge clk);

        issue(1'b1, 8'hAA, 8'h55, 1'b0, acc);
        issue(1'b0, 8'hAA, 8'h00, 1'b0, acc);
        issue(1'b1, 8'h10, 8'h01, 1'b0, acc);
        issue(1'b0, 8'h10, 8'h00, 1'b1, acc);

        for (int i = 0; i < 30; i++)
            issue(1'($urandom), addrs[$urandom_range(0, 7)], 8'($urandom),
                  1'($urandom), acc);
        drain();

        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_check("idle_reset");
        rst = 1'b0;
        model_last = 8'h00;

        // Abort a read at c15 of its data frame, then read the address again.
        issue(1'b0, 8'h10, 8'h00, 1'b0, acc);
        while (cyc < acc + 28 + GAP) @(negedge clk);
        chk("abort_at_recv", SS_n, 1'b0);
        rst = 1'b1;
        abort_pending = 1;
        void'(rq.pop_back());
        @(negedge clk);
        chk("abort_ss_n", SS_n, 1'b1);
        chk("abort_mosi", MOSI, 1'b0);
        chk("abort_resp_valid", resp_valid, 1'b0);
        rst = 1'b0;
        model_last = 8'h00;
        repeat (40) @(negedge clk);
        issue(1'b0, 8'h10, 8'h00, 1'b0, acc);
        issue(1'b1, 8'hAA, 8'h3C, 1'b1, acc);
        issue(1'b0, 8'hAA, 8'h00, 1'b1, acc);
        drain();

        // GAP=3 instance: two back-to-back writes, valid held throughout.
        w3e[0] = 10'h033; w3e[1] = 10'h15A; w3e[2] = 10'h044; w3e[3] = 10'h1C3;
        rv3 = 1'b1; rw3 = 1'b1; ra3 = 8'h33; rd3 = 8'h5A;
        nacc = 0; chg = 0;
        for (int k = 0; k < 64; k++) begin
            ss3_log[k] = ss3;
            m3_log[k]  = mosi3;
            if (resp3 === 1'b1) resp_k.push_back(k);
            if (chg) begin
                chg = 0;
                if (nacc == 1) begin ra3 = 8'h44; rd3 = 8'hC3; end
                else rv3 = 1'b0;
            end
            if (rv3 && rr3 === 1'b1) begin nacc++; chg = 1; end
            @(negedge clk);
        end
        rv3 = 1'b0;
        for (int i = 0; i < 16; i++) begin runs[i] = 0; rs[i] = 0; end
        nr = 0; cur = ss3_log[1]; len = 1;
        for (int k = 2; k < 64; k++) begin
            if (ss3_log[k] === cur) len++;
            else begin
                if (nr < 16) begin runs[nr] = len; rs[nr] = k - len; end
                nr++; cur = ss3_log[k]; len = 1;
            end
        end
        chk("g3_first_low", ss3_log[1], 1'b0);
        for (int i = 0; i < 7; i++) chk($sformatf("g3_run%0d", i), runs[i], (i % 2) ? 3 : 12);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 10; j++) w[9-j] = m3_log[(rs[2*i] + 2 + j) % 64];
            chk($sformatf("g3_word%0d", i), w, w3e[i]);
        end
        chk("g3_resp_count", resp_k.size(), 2);
        if (resp_k.size() >= 2) begin
            chk("g3_latency", resp_k[0], 30);
            chk("g3_b2b_latency", resp_k[1], 60);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_ram_sequencer.md
# spi_ram_sequencer

Bus-side controller that drives the SPI slave + single-port RAM wrapper as an SPI master. It accepts single-byte read/write requests over a valid/ready handshake. Each request expands into the two-frame command sequence the wrapper expects: address frame, then data frame. On reads it captures the 8-bit MISO reply. It sits between a host/CPU-side requester and the wrapper's `SS_n`/`MOSI`/`MISO` pins, on the same clock.

## Interface
- `GAP`, default 1: SS_n-high cycles after each frame, minimum 1.
- `clk` input 1: clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: sequencer idle and able to accept.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input 8: RAM address.
- `req_wdata` input 8: write data; ignored on reads.
- `resp_valid` output 1: one-cycle pulse at operation completion.
- `resp_rdata` output 8: read data, valid with `resp_valid` on reads.
- `SS_n` output 1: slave select to wrapper, active low.
- `MOSI` output 1: serial data to wrapper.
- `MISO` input 1: serial data from wrapper.

## Operation
- Accept when `req_valid && req_ready`. Latch `req_write`, `req_addr` and `req_wdata`. `req_ready` drops the next cycle.
- Write op:
  - frame A sends code 00 + addr.
  - frame B sends code 01 + wdata.
- Read op:
  - frame A sends code 10 + addr.
  - frame B sends code 11 + 0x00 dummy payload, then receives 8 bits.
- Frame layout is counted in cycles from the first SS_n-low cycle, c0:
  - c0 is START: SS_n=0, MOSI=0, so the slave leaves IDLE.
  - c1 is SEL: MOSI=code[1], the slave's CHK_CMD decision bit.
  - c2..c11 is SHIFT: MOSI = 10-bit word {code[1:0], payload[7:0]}, MSB first.
  - Frames 00/01/10 end after c11.
  - Frame 11 only:
    - c12 is WAIT: MOSI=0.
    - c13..c20 is RECV: sample MISO each cycle, MSB first, into a shift register.
- GAP state: SS_n=1, MOSI=0 for `GAP` cycles after every frame.
- After frame B's GAP: return to IDLE and pulse `resp_valid`.
  - On reads, `resp_rdata` = captured byte.
  - On writes, `resp_rdata` holds its previous value.
- State machine:
  - IDLE → START on accept.
  - START → SEL → SHIFT (10 cycles).
  - SHIFT → GAP, or → WAIT if frame 11.
  - WAIT → RECV (8 cycles) → GAP.
  - GAP → START (frame B) or → IDLE (after frame B).
- Counters:
  - 4-bit bit counter for SHIFT/RECV.
  - GAP counter sized for the parameter.
  - 1-bit phase flag for frame A/B.

## Timing
- Reset values:
  - `SS_n`=1, `MOSI`=0.
  - `req_ready`=1, `resp_valid`=0, `resp_rdata`=0x00.
  - state = IDLE.
- All outputs are registered.
- Accept at edge T puts c0 of frame A at cycle T+1.
- Write latency: accept to `resp_valid` = 12+GAP+12+GAP cycles. This is 26 for GAP=1.
- Read latency = 12+GAP+21+GAP cycles. This is 35 for GAP=1.
- `req_ready` returns high in the same cycle `resp_valid` pulses. A back-to-back request may be accepted that cycle. Its frame A starts the next cycle, so SS_n has been high ≥ GAP cycles.
- `req_valid` while busy is ignored, not queued. The requester must hold it until `req_ready`.
- Request fields change after accept: no effect on the running op.
- `rst` mid-frame:
  - at the next edge, SS_n=1, MOSI=0, state IDLE, no `resp_valid`.
  - Partial RAM effects (e.g. address written but not data) are acceptable.
- MISO is ignored outside RECV.

## Test plan
- Reset: hold `rst` 3 cycles mid-idle → `SS_n`=1, `MOSI`=0, `req_ready`=1, `resp_valid`=0.
- Write 0x55 to 0xAA:
  - MOSI frame A = 0,0,00_1010_1010; frame B = 0,0,01_0101_0101.
  - SS_n low 12 cycles, high 1 cycle, low 12 cycles.
  - `resp_valid` at accept+26.
- Read 0xAA after the above:
  - frame A carries 10_1010_1010; frame B carries 11_0000_0000.
  - `resp_rdata`=0x55 with `resp_valid` at accept+35.
- Back-to-back:
  - write 0x01→0x10, then read 0x10 accepted in the `resp_valid` cycle.
  - SS_n high exactly GAP cycles between ops.
  - read returns 0x01.
- GAP=3 instance: every inter-frame SS_n-high gap is 3 cycles; write latency = 30.
- Reset asserted at c15 of a read's frame B:
  - SS_n=1 next cycle, no `resp_valid`.
  - a subsequent read of the same address returns the RAM content written earlier.
